charlie_frame_scheduler: RTL and testbench



---
 rtl/charlie_frame_scheduler_pkg.sv | 16 +
 rtl/charlie_slot_timer.sv | 41 ++++
 rtl/charlie_frame_scheduler.sv | 121 ++++++++++++
 tb/tb_charlie_frame_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/charlie_frame_scheduler_pkg.sv
// Shared definitions for the charlieplexed LED frame scheduler:
// default geometry and the scan FSM state encoding.
package charlie_frame_scheduler_pkg;

  localparam int LED_COUNT_DEF = 64;
  localparam int IDX_W_DEF     = 6;
  localparam int DWELL_W_DEF   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_BLANK = 2'd2,
    ST_SWAP  = 2'd3
  } state_t;

endpackage

// File: rtl/charlie_slot_timer.sv
// Dwell counter for one LED slot. The limit is taken from dwell_cfg_i on the
// first run cycle of a slot and held for the rest of it.
module charlie_slot_timer
  import charlie_frame_scheduler_pkg::*;
#(
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run_i,
  input  logic [DWELL_W-1:0] dwell_cfg_i,
  output logic               tc_o
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] limit_q, limit_d;
  logic [DWELL_W-1:0] limit;

  always_comb begin
    // A zero count while running marks the first on-cycle of the slot.
    limit   = (cnt_q == '0) ? dwell_cfg_i : limit_q;
    tc_o    = run_i && (cnt_q == limit);
    limit_d = limit_q;
    cnt_d   = '0;
    if (run_i) begin
      limit_d = limit;
      cnt_d   = tc_o ? '0 : cnt_q + DWELL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      limit_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
    end
  end

endmodule

// File: rtl/charlie_frame_scheduler.sv
// Charlieplexed LED frame scanner: walks every LED index with a dwell-length
// on-window plus one blanking cycle, and swaps in the staging frame at frame end.
module charlie_frame_scheduler
  import charlie_frame_scheduler_pkg::*;
#(
  parameter int LED_COUNT = LED_COUNT_DEF,
  parameter int IDX_W     = IDX_W_DEF,
  parameter int DWELL_W   = DWELL_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 swap_req,
  input  logic [DWELL_W-1:0]   dwell_cfg,
  input  logic [LED_COUNT-1:0] frame_in,
  output logic [IDX_W-1:0]     charlie_index,
  output logic                 led_on,
  output logic                 frame_start,
  output logic                 swap_ack,
  output logic [7:0]           frame_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LED_COUNT - 1);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [7:0]             frame_cnt_q, frame_cnt_d;
  logic                   pending_q, pending_d;
  logic [LED_COUNT-1:0]   active_q, active_d;
  logic                   led_on_q, led_on_d;
  logic                   frame_start_q, frame_start_d;
  logic                   swap_ack_q, swap_ack_d;
  logic                   slot_tc;

  charlie_slot_timer #(
    .DWELL_W(DWELL_W)
  ) u_slot_timer (
    .clk        (clk),
    .rst        (rst),
    .run_i      (state_q == ST_SCAN),
    .dwell_cfg_i(dwell_cfg),
    .tc_o       (slot_tc)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    pending_d   = pending_q | swap_req;
    active_d    = active_q;

    case (state_q)
      ST_IDLE: begin
        idx_d   = '0;
        state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (slot_tc) state_d = ST_BLANK;
      end
      ST_BLANK: begin
        if (idx_q == LAST_IDX) begin
          idx_d       = '0;
          frame_cnt_d = frame_cnt_q + 8'd1;
          state_d     = (pending_q || swap_req) ? ST_SWAP : ST_SCAN;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_SCAN;
        end
      end
      ST_SWAP: begin
        // A request landing in this very cycle survives for the next frame end.
        active_d  = frame_in;
        pending_d = swap_req;
        idx_d     = '0;
        state_d   = ST_SCAN;
      end
      default: state_d = ST_IDLE;
    endcase

    // Disable wins everywhere; a SWAP in progress still commits its copy above.
    if (!enable) begin
      state_d     = ST_IDLE;
      idx_d       = '0;
      frame_cnt_d = frame_cnt_q;
    end

    // Outputs are registered from the next state so they line up with it.
    led_on_d      = (state_d == ST_SCAN) && active_d[idx_d];
    frame_start_d = (state_d == ST_SCAN) && (state_q != ST_SCAN) && (idx_d == '0);
    swap_ack_d    = (state_d == ST_SWAP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      frame_cnt_q   <= '0;
      pending_q     <= 1'b0;
      active_q      <= '0;
      led_on_q      <= 1'b0;
      frame_start_q <= 1'b0;
      swap_ack_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      frame_cnt_q   <= frame_cnt_d;
      pending_q     <= pending_d;
      active_q      <= active_d;
      led_on_q      <= led_on_d;
      frame_start_q <= frame_start_d;
      swap_ack_q    <= swap_ack_d;
    end
  end

  assign charlie_index = idx_q;
  assign led_on        = led_on_q;
  assign frame_start   = frame_start_q;
  assign swap_ack      = swap_ack_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_charlie_frame_scheduler.sv
// Directed bench for charlie_frame_scheduler: per-cycle output capture checked
// against hand-computed vector tables, plus reset/enable corner sequences.
module tb_charlie_frame_scheduler;

  localparam int LOGN = 700;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        swap_req = 1'b0;
  logic [3:0]  dwell_cfg = 4'd0;
  logic [63:0] frame_in = 64'd0;
  logic [5:0]  charlie_index;
  logic        led_on;
  logic        frame_start;
  logic        swap_ack;
  logic [7:0]  frame_cnt;

  always #5 clk = ~clk;

  charlie_frame_scheduler #(
    .LED_COUNT(64),
    .IDX_W    (6),
    .DWELL_W  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .swap_req     (swap_req),
    .dwell_cfg    (dwell_cfg),
    .frame_in     (frame_in),
    .charlie_index(charlie_index),
    .led_on       (led_on),
    .frame_start  (frame_start),
    .swap_ack     (swap_ack),
    .frame_cnt    (frame_cnt)
  );

  typedef struct {
    string      name;
    int         cyc;
    logic       led;
    logic [5:0] idx;
    logic       fs;
    logic       ack;
    int         fcnt;   // -1: not checked
  } vec_t;

  typedef struct {
    int          at;
    logic        sw;
    logic [63:0] fin;
    logic        en;
  } evt_t;

  vec_t vq[$];
  evt_t sched[$];

  logic       led_log [0:LOGN-1];
  logic [5:0] idx_log [0:LOGN-1];
  logic       fs_log  [0:LOGN-1];
  logic       ack_log [0:LOGN-1];
  logic [7:0] fc_log  [0:LOGN-1];

  int tests = 0;
  int fails = 0;

  logic [63:0] ones = {64{1'b1}};
  logic [63:0] pa1  = 64'h1111_2222_3333_4444;
  logic [63:0] pa2  = 64'h2222_4444_8888_1111;
  logic [63:0] pa3  = 64'hA5A5_0F0F_1234_8001;
  logic [63:0] pa4  = 64'hFFFF_0000_FFFF_0000;
  logic [63:0] pb1  = 64'h0123_4567_89AB_CDEF;
  logic [63:0] pb2  = 64'hFEDC_BA98_7654_3211;
  logic [63:0] pb3  = 64'h5555_AAAA_3333_CCCD;
  logic [63:0] pc1  = 64'hF00D_0000_0013_0001;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input int cyc, input logic led, input logic [5:0] idx,
                         input logic fs, input logic ack, input int fcnt);
    vq.push_back('{name, cyc, led, idx, fs, ack, fcnt});
  endtask

  task automatic add_evt(input int at, input logic sw, input logic [63:0] fin, input logic en);
    sched.push_back('{at, sw, fin, en});
  endtask

  // which: 0 = frame_start, 1 = swap_ack
  task automatic wait_sig(input int which, input int max, input string name);
    int n;
    logic s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      s = (which == 0) ? frame_start : swap_ack;
    end while (s !== 1'b1 && n < max);
    chk(name, {63'd0, s}, 64'd1);
  endtask

  // Sample index 0 is the current negedge; scheduled inputs apply after sampling.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      led_log[i] = led_on;
      idx_log[i] = charlie_index;
      fs_log[i]  = frame_start;
      ack_log[i] = swap_ack;
      fc_log[i]  = frame_cnt;
      swap_req   = 1'b0;
      foreach (sched[j]) begin
        if (sched[j].at == i) begin
          frame_in = sched[j].fin;
          swap_req = sched[j].sw;
          enable   = sched[j].en;
        end
      end
    end
    sched.delete();
  endtask

  task automatic check_vecs(input string tag);
    foreach (vq[k]) begin
      chk($sformatf("%s/%s led", tag, vq[k].name), {63'd0, led_log[vq[k].cyc]}, {63'd0, vq[k].led});
      chk($sformatf("%s/%s idx", tag, vq[k].name), {58'd0, idx_log[vq[k].cyc]}, {58'd0, vq[k].idx});
      chk($sformatf("%s/%s fs", tag, vq[k].name), {63'd0, fs_log[vq[k].cyc]}, {63'd0, vq[k].fs});
      chk($sformatf("%s/%s ack", tag, vq[k].name), {63'd0, ack_log[vq[k].cyc]}, {63'd0, vq[k].ack});
      if (vq[k].fcnt >= 0)
        chk($sformatf("%s/%s fcnt", tag, vq[k].name), {56'd0, fc_log[vq[k].cyc]}, 64'(vq[k].fcnt));
    end
    $display("[TB] %s: %0d vectors applied", tag, vq.size());
    vq.delete();
  endtask

  function automatic int count_led(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) c += int'(led_log[i]);
    return c;
  endfunction

  function automatic int count_ack(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) c += int'(ack_log[i]);
    return c;
  endfunction

  function automatic int count_fs(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) c += int'(fs_log[i]);
    return c;
  endfunction

  // Rebuild the displayed frame from a dwell_cfg=0 frame starting at 'start'.
  function automatic logic [63:0] frame_at(input int start);
    logic [63:0] f;
    for (int k = 0; k < 64; k++) f[k] = led_log[start + 2 * k];
    return f;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset idx", {58'd0, charlie_index}, 64'd0);
    chk("reset led", {63'd0, led_on}, 64'd0);
    chk("reset fs", {63'd0, frame_start}, 64'd0);
    chk("reset ack", {63'd0, swap_ack}, 64'd0);
    chk("reset fcnt", {56'd0, frame_cnt}, 64'd0);

    // A: dark first frame, swap at frame end, then 1-of-2 on, 128-cycle period
    dwell_cfg = 4'd0;
    frame_in  = ones;
    enable    = 1'b1;
    rst       = 1'b0;
    wait_sig(0, 8, "A start");
    add_evt(5, 1'b1, ones, 1'b1);
    add_vec("c0",   0,   1'b0, 6'd0,  1'b1, 1'b0, 0);
    add_vec("c1",   1,   1'b0, 6'd0,  1'b0, 1'b0, 0);
    add_vec("c2",   2,   1'b0, 6'd1,  1'b0, 1'b0, 0);
    add_vec("c127", 127, 1'b0, 6'd63, 1'b0, 1'b0, 0);
    add_vec("c128", 128, 1'b0, 6'd0,  1'b0, 1'b1, 1);
    add_vec("c129", 129, 1'b1, 6'd0,  1'b1, 1'b0, 1);
    add_vec("c130", 130, 1'b0, 6'd0,  1'b0, 1'b0, -1);
    add_vec("c131", 131, 1'b1, 6'd1,  1'b0, 1'b0, -1);
    add_vec("c255", 255, 1'b1, 6'd63, 1'b0, 1'b0, -1);
    add_vec("c256", 256, 1'b0, 6'd63, 1'b0, 1'b0, -1);
    add_vec("c257", 257, 1'b1, 6'd0,  1'b1, 1'b0, 2);
    capture(260);
    check_vecs("A");
    chk("A dark frame", 64'(count_led(0, 127)), 64'd0);
    chk("A lit count", 64'(count_led(129, 256)), 64'd64);
    chk("A ack count", 64'(count_ack(0, 259)), 64'd1);
    chk("A fs between", 64'(count_fs(130, 256)), 64'd0);

    // B: dwell 3, single LED 0; frame_in change mid-frame must not show
    dwell_cfg = 4'd3;
    frame_in  = 64'd1;
    swap_req  = 1'b1;
    @(negedge clk);
    swap_req  = 1'b0;
    wait_sig(1, 400, "B ack");
    wait_sig(0, 4, "B start");
    add_evt(100, 1'b0, ones, 1'b1);
    add_vec("c0",   0,   1'b1, 6'd0,  1'b1, 1'b0, -1);
    add_vec("c3",   3,   1'b1, 6'd0,  1'b0, 1'b0, -1);
    add_vec("c4",   4,   1'b0, 6'd0,  1'b0, 1'b0, -1);
    add_vec("c5",   5,   1'b0, 6'd1,  1'b0, 1'b0, -1);
    add_vec("c319", 319, 1'b0, 6'd63, 1'b0, 1'b0, -1);
    add_vec("c320", 320, 1'b1, 6'd0,  1'b1, 1'b0, -1);
    add_vec("c640", 640, 1'b1, 6'd0,  1'b1, 1'b0, -1);
    capture(660);
    check_vecs("B");
    chk("B lit f0", 64'(count_led(0, 319)), 64'd4);
    chk("B lit f1", 64'(count_led(320, 639)), 64'd4);
    chk("B fs between", 64'(count_fs(1, 319)), 64'd0);

    // C: three requests in one frame coalesce into one swap of the last frame_in
    dwell_cfg = 4'd0;
    wait_sig(0, 400, "C start");
    add_evt(10,  1'b1, pa1, 1'b1);
    add_evt(50,  1'b1, pa2, 1'b1);
    add_evt(90,  1'b1, pa3, 1'b1);
    add_evt(200, 1'b0, pa4, 1'b1);
    add_vec("c128", 128, 1'b0,   6'd0, 1'b0, 1'b1, -1);
    add_vec("c129", 129, pa3[0], 6'd0, 1'b1, 1'b0, -1);
    add_vec("c257", 257, pa3[0], 6'd0, 1'b1, 1'b0, -1);
    capture(400);
    check_vecs("C");
    chk("C ack count", 64'(count_ack(0, 399)), 64'd1);
    chk("C active f1", frame_at(129), pa3);
    chk("C active f2", frame_at(257), pa3);

    // D: request coincident with SWAP yields a second swap one frame later
    wait_sig(0, 200, "D start");
    add_evt(3,   1'b1, pb1, 1'b1);
    add_evt(128, 1'b1, pb2, 1'b1);
    add_evt(129, 1'b0, pb3, 1'b1);
    add_vec("c128", 128, 1'b0,   6'd0, 1'b0, 1'b1, -1);
    add_vec("c129", 129, pb2[0], 6'd0, 1'b1, 1'b0, -1);
    add_vec("c257", 257, 1'b0,   6'd0, 1'b0, 1'b1, -1);
    add_vec("c258", 258, pb3[0], 6'd0, 1'b1, 1'b0, -1);
    capture(400);
    check_vecs("D");
    chk("D ack count", 64'(count_ack(0, 399)), 64'd2);
    chk("D active f1", frame_at(129), pb2);
    chk("D active f2", frame_at(258), pb3);

    // E: enable dropped at index 37 for 10 cycles; pending swap survives
    wait_sig(0, 200, "E start");
    add_evt(5,  1'b1, pc1, 1'b1);
    add_evt(74, 1'b0, pc1, 1'b0);
    add_evt(84, 1'b0, pc1, 1'b1);
    add_vec("c74",  74,  pb3[37], 6'd37, 1'b0, 1'b0, -1);
    add_vec("c75",  75,  1'b0,    6'd0,  1'b0, 1'b0, -1);
    add_vec("c84",  84,  1'b0,    6'd0,  1'b0, 1'b0, -1);
    add_vec("c85",  85,  pc1[0],  6'd0,  1'b1, 1'b0, -1);
    add_vec("c213", 213, 1'b0,    6'd0,  1'b0, 1'b1, -1);
    add_vec("c214", 214, pc1[0],  6'd0,  1'b1, 1'b0, -1);
    capture(350);
    check_vecs("E");
    chk("E idle dark", 64'(count_led(75, 84)), 64'd0);
    chk("E ack count", 64'(count_ack(0, 349)), 64'd1);
    chk("E active", frame_at(214), pc1);

    // F: asynchronous reset at index 20 mid-frame
    wait_sig(0, 200, "F start");
    repeat (40) @(negedge clk);
    chk("F pre idx", {58'd0, charlie_index}, 64'd20);
    chk("F pre led", {63'd0, led_on}, {63'd0, pc1[20]});
    chk("F pre fcnt nonzero", {63'd0, (frame_cnt != 8'd0)}, 64'd1);
    rst = 1'b1;
    #1;
    chk("F rst idx", {58'd0, charlie_index}, 64'd0);
    chk("F rst led", {63'd0, led_on}, 64'd0);
    chk("F rst fs", {63'd0, frame_start}, 64'd0);
    chk("F rst ack", {63'd0, swap_ack}, 64'd0);
    chk("F rst fcnt", {56'd0, frame_cnt}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    frame_in = ones;
    rst      = 1'b0;
    wait_sig(0, 8, "F restart");
    capture(130);
    chk("F fcnt after", {56'd0, fc_log[0]}, 64'd0);
    chk("F dark frame", 64'(count_led(0, 127)), 64'd0);
    chk("F next fs", {63'd0, fs_log[128]}, 64'd1);
    chk("F fcnt one", {56'd0, fc_log[128]}, 64'd1);
    $display("[TB] F: reset sequence applied");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
